ann_memory_core: RTL and testbench

ANN_MEMORY_CORE -- requirements
Module: ann_memory_core

---
 rtl/ann_memory_core.sv | 198 +++++++++++++++++++
 tb/tb_ann_memory_core.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ann_memory_core.sv
// Data and weight storage for a small fixed-topology ANN: two independent ports, registered read responses.
// Optional feature: define ANN_MEMORY_CORE_WRITE_ACK_EN to acknowledge writes with a one-cycle response.
module ann_memory_core #(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3,
  localparam int DATA_COUNTER_WIDTH           = $clog2(NUMBER_OF_HIDDEN_NODE_LAYER_1),
  localparam int WEIGHT_ADDR_WIDTH            = 11
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_ram_data_enable,
  input  logic                          i_rw_data_select,
  input  logic [LAYER_WIDTH-1:0]        i_data_layer,
  input  logic [DATA_COUNTER_WIDTH-1:0] i_data_addr,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_ram_weight_enable,
  input  logic                          i_rw_weight_select,
  input  logic [LAYER_WIDTH-1:0]        i_weight_layer,
  input  logic [WEIGHT_ADDR_WIDTH-1:0]  i_weight_addr,
  input  logic [DATA_WIDTH-1:0]         i_weight,
  output logic                          o_data_valid,
  output logic [LAYER_WIDTH-1:0]        o_data_layer,
  output logic [DATA_COUNTER_WIDTH-1:0] o_data_addr,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_weight_valid,
  output logic [LAYER_WIDTH-1:0]        o_weight_layer,
  output logic [WEIGHT_ADDR_WIDTH-1:0]  o_weight_addr,
  output logic [DATA_WIDTH-1:0]         o_weight
);

  localparam int NI = NUMBER_OF_INPUT_NODE;
  localparam int H1 = NUMBER_OF_HIDDEN_NODE_LAYER_1;
  localparam int H2 = NUMBER_OF_HIDDEN_NODE_LAYER_2;
  localparam int NO = NUMBER_OF_OUTPUT_NODE;
  localparam int W1 = H1 * (NI + 1);
  localparam int W2 = H2 * (H1 + 1);
  localparam int W3 = NO * (H2 + 1);

  // Bank index widths; addresses are range-checked before being trimmed to these.
  localparam int AI  = (NI > 1) ? $clog2(NI) : 1;
  localparam int AH1 = (H1 > 1) ? $clog2(H1) : 1;
  localparam int AH2 = (H2 > 1) ? $clog2(H2) : 1;
  localparam int AO  = (NO > 1) ? $clog2(NO) : 1;
  localparam int AW1 = (W1 > 1) ? $clog2(W1) : 1;
  localparam int AW2 = (W2 > 1) ? $clog2(W2) : 1;
  localparam int AW3 = (W3 > 1) ? $clog2(W3) : 1;

  logic [DATA_WIDTH-1:0] r_mem_in  [NI];
  logic [DATA_WIDTH-1:0] r_mem_h1  [H1];
  logic [DATA_WIDTH-1:0] r_mem_h2  [H2];
  logic [DATA_WIDTH-1:0] r_mem_out [NO];
  logic [DATA_WIDTH-1:0] r_mem_w1  [W1];
  logic [DATA_WIDTH-1:0] r_mem_w2  [W2];
  logic [DATA_WIDTH-1:0] r_mem_w3  [W3];

  logic                          r_data_valid;
  logic [LAYER_WIDTH-1:0]        r_data_layer;
  logic [DATA_COUNTER_WIDTH-1:0] r_data_addr;
  logic [DATA_WIDTH-1:0]         r_data;
  logic                          r_weight_valid;
  logic [LAYER_WIDTH-1:0]        r_weight_layer;
  logic [WEIGHT_ADDR_WIDTH-1:0]  r_weight_addr;
  logic [DATA_WIDTH-1:0]         r_weight;

  logic                  w_d_in_range;
  logic                  w_w_in_range;
  logic [DATA_WIDTH-1:0] w_d_rd;
  logic [DATA_WIDTH-1:0] w_w_rd;

  always_comb begin
    w_d_in_range = 1'b0;
    w_d_rd       = '0;
    case (i_data_layer)
      2'd0: begin
        w_d_in_range = 32'(i_data_addr) < NI;
        if (w_d_in_range) w_d_rd = r_mem_in[i_data_addr[AI-1:0]];
      end
      2'd1: begin
        w_d_in_range = 32'(i_data_addr) < H1;
        if (w_d_in_range) w_d_rd = r_mem_h1[i_data_addr[AH1-1:0]];
      end
      2'd2: begin
        w_d_in_range = 32'(i_data_addr) < H2;
        if (w_d_in_range) w_d_rd = r_mem_h2[i_data_addr[AH2-1:0]];
      end
      default: begin
        w_d_in_range = 32'(i_data_addr) < NO;
        if (w_d_in_range) w_d_rd = r_mem_out[i_data_addr[AO-1:0]];
      end
    endcase
  end

  // Weight layer 0 has no bank: it is never in range.
  always_comb begin
    w_w_in_range = 1'b0;
    w_w_rd       = '0;
    case (i_weight_layer)
      2'd1: begin
        w_w_in_range = 32'(i_weight_addr) < W1;
        if (w_w_in_range) w_w_rd = r_mem_w1[i_weight_addr[AW1-1:0]];
      end
      2'd2: begin
        w_w_in_range = 32'(i_weight_addr) < W2;
        if (w_w_in_range) w_w_rd = r_mem_w2[i_weight_addr[AW2-1:0]];
      end
      2'd3: begin
        w_w_in_range = 32'(i_weight_addr) < W3;
        if (w_w_in_range) w_w_rd = r_mem_w3[i_weight_addr[AW3-1:0]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_ram_data_enable && !i_rw_data_select && w_d_in_range) begin
      case (i_data_layer)
        2'd0:    r_mem_in[i_data_addr[AI-1:0]]   <= i_data;
        2'd1:    r_mem_h1[i_data_addr[AH1-1:0]]  <= i_data;
        2'd2:    r_mem_h2[i_data_addr[AH2-1:0]]  <= i_data;
        default: r_mem_out[i_data_addr[AO-1:0]]  <= i_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_ram_weight_enable && !i_rw_weight_select && w_w_in_range) begin
      case (i_weight_layer)
        2'd1:    r_mem_w1[i_weight_addr[AW1-1:0]] <= i_weight;
        2'd2:    r_mem_w2[i_weight_addr[AW2-1:0]] <= i_weight;
        2'd3:    r_mem_w3[i_weight_addr[AW3-1:0]] <= i_weight;
        default: ;
      endcase
    end
  end

  // Response registers; layer/addr/value hold whenever no response is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_valid   <= 1'b0;
      r_data_layer   <= '0;
      r_data_addr    <= '0;
      r_data         <= '0;
      r_weight_valid <= 1'b0;
      r_weight_layer <= '0;
      r_weight_addr  <= '0;
      r_weight       <= '0;
    end else begin
      r_data_valid   <= 1'b0;
      r_weight_valid <= 1'b0;
      if (i_ram_data_enable) begin
        if (i_rw_data_select) begin
          r_data_valid <= 1'b1;
          r_data_layer <= i_data_layer;
          r_data_addr  <= i_data_addr;
          r_data       <= w_d_rd;
        end
`ifdef ANN_MEMORY_CORE_WRITE_ACK_EN
        else begin
          r_data_valid <= 1'b1;
          r_data_layer <= i_data_layer;
          r_data_addr  <= i_data_addr;
          r_data       <= w_d_in_range ? i_data : '0;
        end
`endif
      end
      if (i_ram_weight_enable) begin
        if (i_rw_weight_select) begin
          r_weight_valid <= 1'b1;
          r_weight_layer <= i_weight_layer;
          r_weight_addr  <= i_weight_addr;
          r_weight       <= w_w_rd;
        end
`ifdef ANN_MEMORY_CORE_WRITE_ACK_EN
        else begin
          r_weight_valid <= 1'b1;
          r_weight_layer <= i_weight_layer;
          r_weight_addr  <= i_weight_addr;
          r_weight       <= w_w_in_range ? i_weight : '0;
        end
`endif
      end
    end
  end

  assign o_data_valid   = r_data_valid;
  assign o_data_layer   = r_data_layer;
  assign o_data_addr    = r_data_addr;
  assign o_data         = r_data;
  assign o_weight_valid = r_weight_valid;
  assign o_weight_layer = r_weight_layer;
  assign o_weight_addr  = r_weight_addr;
  assign o_weight       = r_weight;

endmodule

// File: tb/tb_ann_memory_core.sv
// Self-checking bench for ann_memory_core: directed scenarios plus randomized traffic against a bank-level model.
module tb_ann_memory_core;

  localparam int DW = 32;

`ifdef ANN_MEMORY_CORE_WRITE_ACK_EN
  localparam bit ACK_BIT = 1'b1;
`else
  localparam bit ACK_BIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_ram_data_enable, i_rw_data_select;
  logic [1:0]  i_data_layer;
  logic [4:0]  i_data_addr;
  logic [31:0] i_data;
  logic        i_ram_weight_enable, i_rw_weight_select;
  logic [1:0]  i_weight_layer;
  logic [10:0] i_weight_addr;
  logic [31:0] i_weight;
  logic        o_data_valid, o_weight_valid;
  logic [1:0]  o_data_layer, o_weight_layer;
  logic [4:0]  o_data_addr;
  logic [10:0] o_weight_addr;
  logic [31:0] o_data, o_weight;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_data [4][32];
  logic [DW-1:0] m_w    [4][1056];

  always #5 clk = ~clk;

  ann_memory_core dut (
    .clk(clk), .rst_n(rst_n),
    .i_ram_data_enable(i_ram_data_enable), .i_rw_data_select(i_rw_data_select),
    .i_data_layer(i_data_layer), .i_data_addr(i_data_addr), .i_data(i_data),
    .i_ram_weight_enable(i_ram_weight_enable), .i_rw_weight_select(i_rw_weight_select),
    .i_weight_layer(i_weight_layer), .i_weight_addr(i_weight_addr), .i_weight(i_weight),
    .o_data_valid(o_data_valid), .o_data_layer(o_data_layer), .o_data_addr(o_data_addr), .o_data(o_data),
    .o_weight_valid(o_weight_valid), .o_weight_layer(o_weight_layer), .o_weight_addr(o_weight_addr),
    .o_weight(o_weight)
  );

  // Bank sizes from the network topology: 2 inputs, 32/32 hidden, 3 outputs.
  function automatic int dsize(input int l);
    case (l)
      0: return 2;
      1: return 32;
      2: return 32;
      default: return 3;
    endcase
  endfunction

  function automatic int wsize(input int l);
    case (l)
      0: return 0;
      1: return 32 * (2 + 1);
      2: return 32 * (32 + 1);
      default: return 3 * (32 + 1);
    endcase
  endfunction

  function automatic logic [DW-1:0] d_exp(input int l, input int a);
    if (a < dsize(l)) return m_data[l][a];
    return '0;
  endfunction

  function automatic logic [DW-1:0] w_exp(input int l, input int a);
    if (a < wsize(l)) return m_w[l][a];
    return '0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_d(input bit en, input bit rw, input int l, input int a, input logic [31:0] v);
    i_ram_data_enable = en;
    i_rw_data_select  = rw;
    i_data_layer      = 2'(l);
    i_data_addr       = 5'(a);
    i_data            = v;
    if (en && !rw && a < dsize(l)) m_data[l][a] = v;
  endtask

  task automatic drv_w(input bit en, input bit rw, input int l, input int a, input logic [31:0] v);
    i_ram_weight_enable = en;
    i_rw_weight_select  = rw;
    i_weight_layer      = 2'(l);
    i_weight_addr       = 11'(a);
    i_weight            = v;
    if (en && !rw && a < wsize(l)) m_w[l][a] = v;
  endtask

  task automatic test_reset();
    drv_d(0, 0, 0, 0, 0);
    drv_w(0, 0, 0, 0, 0);
    #2;
    checks++;
    if ({o_data_valid, o_data_layer, o_data_addr, o_data} !== '0) begin
      errors++; $display("FAIL reset_data: got %b/%h/%h/%h exp all 0", o_data_valid, o_data_layer, o_data_addr, o_data);
    end
    checks++;
    if ({o_weight_valid, o_weight_layer, o_weight_addr, o_weight} !== '0) begin
      errors++; $display("FAIL reset_weight: got %b/%h/%h/%h exp all 0", o_weight_valid, o_weight_layer, o_weight_addr, o_weight);
    end
    // A read held at an edge while reset is low must not respond.
    drv_d(1, 1, 1, 0, 0);
    drv_w(1, 1, 1, 0, 0);
    step();
    checks++;
    if (o_data_valid !== 1'b0 || o_weight_valid !== 1'b0) begin
      errors++; $display("FAIL reset_read_blocked: got %b/%b exp 0/0", o_data_valid, o_weight_valid);
    end
    drv_d(0, 0, 0, 0, 0);
    drv_w(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    int wl = 1, wa = 0;
    for (int i = 0; i < 96 + 1056 + 99; i++) begin
      if (i < 2) drv_d(1, 0, 0, i, $urandom);
      else if (i < 34) drv_d(1, 0, 1, i - 2, $urandom);
      else if (i < 66) drv_d(1, 0, 2, i - 34, $urandom);
      else if (i < 69) drv_d(1, 0, 3, i - 66, $urandom);
      else drv_d(0, 0, 0, 0, 0);
      drv_w(1, 0, wl, wa, $urandom);
      wa++;
      if (wa == wsize(wl)) begin wl++; wa = 0; end
      step();
      checks++;
      if (o_weight_valid !== ACK_BIT) begin
        errors++; $display("FAIL fill_weight_valid: got %b exp %b at %0d", o_weight_valid, ACK_BIT, i);
      end
      if (i < 69) begin
        checks++;
        if (o_data_valid !== ACK_BIT) begin
          errors++; $display("FAIL fill_data_valid: got %b exp %b at %0d", o_data_valid, ACK_BIT, i);
        end
      end
    end
    drv_d(0, 0, 0, 0, 0);
    drv_w(0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_weight_top();
    drv_w(1, 0, 2, 1055, 32'h3F80_0000);
    step();
    drv_w(1, 1, 2, 1055, 0);
    step();
    checks++;
    if (o_weight_valid !== 1'b1 || o_weight_layer !== 2'd2 || o_weight_addr !== 11'd1055 || o_weight !== 32'h3F80_0000) begin
      errors++; $display("FAIL weight_top: got %b/%0d/%0d/%h exp 1/2/1055/3f800000", o_weight_valid, o_weight_layer, o_weight_addr, o_weight);
    end
    drv_w(0, 0, 0, 0, 0);
    step();
    checks++;
    if (o_weight_valid !== 1'b0 || o_weight_layer !== 2'd2 || o_weight_addr !== 11'd1055 || o_weight !== 32'h3F80_0000) begin
      errors++; $display("FAIL weight_hold: got %b/%0d/%0d/%h exp 0/2/1055/3f800000", o_weight_valid, o_weight_layer, o_weight_addr, o_weight);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drv_d(1, 0, 3, i, 32'(i + 1));
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drv_d(1, 1, 3, i, 0);
      step();
      checks++;
      if (o_data_valid !== 1'b1 || o_data_layer !== 2'd3 || o_data_addr !== 5'(i) || o_data !== 32'(i + 1)) begin
        errors++; $display("FAIL back_to_back[%0d]: got %b/%0d/%0d/%h exp 1/3/%0d/%h", i, o_data_valid, o_data_layer, o_data_addr, o_data, i, i + 1);
      end
    end
    drv_d(0, 0, 0, 0, 0);
    step();
    checks++;
    if (o_data_valid !== 1'b0 || o_data !== 32'd3) begin
      errors++; $display("FAIL back_to_back_end: got %b/%h exp 0/3", o_data_valid, o_data);
    end
  endtask

  task automatic test_dual_port();
    logic [31:0] ed, ew;
    ed = d_exp(0, 1);
    ew = w_exp(1, 95);
    drv_d(1, 1, 0, 1, 0);
    drv_w(1, 1, 1, 95, 0);
    step();
    checks++;
    if (o_data_valid !== 1'b1 || o_data_layer !== 2'd0 || o_data_addr !== 5'd1 || o_data !== ed) begin
      errors++; $display("FAIL dual_data: got %b/%0d/%0d/%h exp 1/0/1/%h", o_data_valid, o_data_layer, o_data_addr, o_data, ed);
    end
    checks++;
    if (o_weight_valid !== 1'b1 || o_weight_layer !== 2'd1 || o_weight_addr !== 11'd95 || o_weight !== ew) begin
      errors++; $display("FAIL dual_weight: got %b/%0d/%0d/%h exp 1/1/95/%h", o_weight_valid, o_weight_layer, o_weight_addr, o_weight, ew);
    end
    drv_d(0, 0, 0, 0, 0);
    drv_w(0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_out_of_range();
    logic [31:0] e1;
    drv_w(1, 0, 0, 5, 32'hDEAD_BEEF);
    drv_d(1, 0, 0, 3, 32'h1234_5678);
    step();
    drv_w(1, 0, 1, 96, 32'hCAFE_F00D);
    drv_d(0, 0, 0, 0, 0);
    step();
    drv_w(1, 1, 3, 99, 0);
    drv_d(1, 1, 0, 3, 0);
    step();
    checks++;
    if (o_weight_valid !== 1'b1 || o_weight_layer !== 2'd3 || o_weight_addr !== 11'd99 || o_weight !== 32'h0) begin
      errors++; $display("FAIL oor_weight_read: got %b/%0d/%0d/%h exp 1/3/99/0", o_weight_valid, o_weight_layer, o_weight_addr, o_weight);
    end
    checks++;
    if (o_data_valid !== 1'b1 || o_data_addr !== 5'd3 || o_data !== 32'h0) begin
      errors++; $display("FAIL oor_data_read: got %b/%0d/%h exp 1/3/0", o_data_valid, o_data_addr, o_data);
    end
    e1 = d_exp(0, 1);
    drv_w(1, 1, 0, 5, 0);
    drv_d(1, 1, 0, 1, 0);
    step();
    checks++;
    if (o_weight_valid !== 1'b1 || o_weight_layer !== 2'd0 || o_weight !== 32'h0) begin
      errors++; $display("FAIL oor_layer0_read: got %b/%0d/%h exp 1/0/0", o_weight_valid, o_weight_layer, o_weight);
    end
    checks++;
    if (o_data !== e1) begin
      errors++; $display("FAIL oor_no_alias: got %h exp %h", o_data, e1);
    end
    drv_w(1, 1, 1, 96, 0);
    drv_d(0, 0, 0, 0, 0);
    step();
    checks++;
    if (o_weight_valid !== 1'b1 || o_weight !== 32'h0) begin
      errors++; $display("FAIL oor_bank_end: got %b/%h exp 1/0", o_weight_valid, o_weight);
    end
    drv_w(0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_random();
    bit          dv = 0, wv = 0, dk = 0, wk = 0;
    int          dl = 0, da = 0, wl = 0, wa = 0;
    logic [31:0] dd = '0, wd = '0;
    bit          en, rw;
    int          l, a;
    logic [31:0] v;
    for (int n = 0; n < 600; n++) begin
      en = ($urandom % 4) != 0;
      rw = $urandom % 2;
      l  = $urandom % 4;
      if ($urandom % 5 == 0) a = $urandom % 32;
      else a = $urandom % dsize(l);
      v  = $urandom;
      dv = 0;
      if (en && rw) begin
        dv = 1; dl = l; da = a; dd = d_exp(l, a); dk = 1;
      end else if (en) begin
        dv = ACK_BIT; dl = l; da = a; dd = (a < dsize(l)) ? v : '0; dk = ACK_BIT;
      end
      drv_d(en, rw, l, a, v);

      en = ($urandom % 4) != 0;
      rw = $urandom % 2;
      l  = $urandom % 4;
      if (l == 0 || $urandom % 5 == 0) a = $urandom % 2048;
      else a = $urandom % wsize(l);
      v  = $urandom;
      wv = 0;
      if (en && rw) begin
        wv = 1; wl = l; wa = a; wd = w_exp(l, a); wk = 1;
      end else if (en) begin
        wv = ACK_BIT; wl = l; wa = a; wd = (a < wsize(l)) ? v : '0; wk = ACK_BIT;
      end
      drv_w(en, rw, l, a, v);

      step();
      checks++;
      if (o_data_valid !== dv || (dk && (o_data_layer !== 2'(dl) || o_data_addr !== 5'(da) || o_data !== dd))) begin
        errors++; $display("FAIL rand_data[%0d]: got %b/%0d/%0d/%h exp %b/%0d/%0d/%h", n, o_data_valid, o_data_layer, o_data_addr, o_data, dv, dl, da, dd);
      end
      checks++;
      if (o_weight_valid !== wv || (wk && (o_weight_layer !== 2'(wl) || o_weight_addr !== 11'(wa) || o_weight !== wd))) begin
        errors++; $display("FAIL rand_weight[%0d]: got %b/%0d/%0d/%h exp %b/%0d/%0d/%h", n, o_weight_valid, o_weight_layer, o_weight_addr, o_weight, wv, wl, wa, wd);
      end
    end
    drv_d(0, 0, 0, 0, 0);
    drv_w(0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_reset_mid();
    logic [31:0] ed, ew;
    drv_d(1, 1, 1, 4, 0);
    drv_w(1, 1, 2, 700, 0);
    step();
    checks++;
    if (o_data_valid !== 1'b1 || o_weight_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre_reset: got %b/%b exp 1/1", o_data_valid, o_weight_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_data_valid, o_data_layer, o_data_addr, o_data, o_weight_valid, o_weight_layer, o_weight_addr, o_weight} !== '0) begin
      errors++; $display("FAIL mid_reset_async: got %b/%h/%b/%h exp all 0", o_data_valid, o_data, o_weight_valid, o_weight);
    end
    step();
    checks++;
    if (o_data_valid !== 1'b0 || o_weight_valid !== 1'b0 || o_data !== '0 || o_weight !== '0) begin
      errors++; $display("FAIL mid_reset_held: got %b/%h/%b/%h exp 0/0/0/0", o_data_valid, o_data, o_weight_valid, o_weight);
    end
    rst_n = 1'b1;
    ed = d_exp(1, 4);
    ew = w_exp(2, 700);
    step();
    checks++;
    if (o_data_valid !== 1'b1 || o_data_addr !== 5'd4 || o_data !== ed) begin
      errors++; $display("FAIL mid_post_data: got %b/%0d/%h exp 1/4/%h", o_data_valid, o_data_addr, o_data, ed);
    end
    checks++;
    if (o_weight_valid !== 1'b1 || o_weight_addr !== 11'd700 || o_weight !== ew) begin
      errors++; $display("FAIL mid_post_weight: got %b/%0d/%h exp 1/700/%h", o_weight_valid, o_weight_addr, o_weight, ew);
    end
    drv_d(0, 0, 0, 0, 0);
    drv_w(0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_write_ack();
    drv_d(1, 0, 1, 31, 32'h4000_0000);
    step();
    checks++;
    if (o_data_valid !== ACK_BIT) begin
      errors++; $display("FAIL write_ack_valid: got %b exp %b", o_data_valid, ACK_BIT);
    end
    drv_d(1, 1, 1, 31, 0);
    step();
    checks++;
    if (o_data_valid !== 1'b1 || o_data_layer !== 2'd1 || o_data_addr !== 5'd31 || o_data !== 32'h4000_0000) begin
      errors++; $display("FAIL write_readback: got %b/%0d/%0d/%h exp 1/1/31/40000000", o_data_valid, o_data_layer, o_data_addr, o_data);
    end
    drv_d(0, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_weight_top();
    test_back_to_back();
    test_dual_port();
    test_out_of_range();
    test_random();
    test_reset_mid();
    test_write_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
